mat_result_drain: RTL

- Read-side counterpart of the systolic matmul `control` unit.
- On the unit's `o_done` pulse, snapshots the flat result matrix `o_C` into a shadow register.
- Streams the snapshot out one W-bit element per beat, row-major, over a valid/ready handshake.
- Downstream consumers (FP16 checker, writeback, host FIFO) never need to hold `o_C` stable.

---
 rtl/mat_result_drain.sv | 60 ++++++
 1 files changed

// File: rtl/mat_result_drain.sv
// mat_result_drain: snapshots i_C on i_done, streams it row-major as o_data/o_valid/i_ready beats tagged by o_row/o_col/o_last; o_busy while streaming, o_overrun sticky on dropped strobes
module mat_result_drain #(
  parameter int W = 16,
  parameter int N = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_done,
  input  logic [W*N*N-1:0]       i_C,
  output logic [W-1:0]           o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_last,
  output logic [$clog2(N)-1:0]   o_row,
  output logic [$clog2(N)-1:0]   o_col,
  output logic                   o_busy,
  output logic                   o_overrun
);
  localparam int RW = $clog2(N);
  localparam int KW = $clog2(N*N);
  localparam logic [RW-1:0] END_IDX = RW'(N-1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;
  logic [W-1:0] sh [N*N];
  logic [KW-1:0] idx;
  assign o_last = o_valid && o_row == END_IDX && o_col == END_IDX;
  assign o_data = o_valid ? sh[idx] : '0;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state     <= IDLE;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
      o_row     <= '0;
      o_col     <= '0;
      idx       <= '0;
      for (int k = 0; k < N*N; k++) sh[k] <= '0;
    end else if (state == IDLE || (i_ready && o_last)) begin
      if (i_done) begin
        for (int k = 0; k < N*N; k++) sh[k] <= i_C[W*(N*N-k)-1 -: W];
        state   <= STREAM;
        o_valid <= 1'b1;
        o_busy  <= 1'b1;
      end else begin
        state   <= IDLE;
        o_valid <= 1'b0;
        o_busy  <= 1'b0;
      end
      o_row <= '0;
      o_col <= '0;
      idx   <= '0;
    end else begin
      if (i_done) o_overrun <= 1'b1;
      if (i_ready) begin
        idx   <= idx + KW'(1);
        o_col <= o_col == END_IDX ? '0 : o_col + RW'(1);
        o_row <= o_col == END_IDX ? o_row + RW'(1) : o_row;
      end
    end
endmodule
